// File: rtl/epot_prog_pkg.sv
// EPOT programming sequencer shared definitions:
// command mode encodings, FSM states and scan-word sizing.
package epot_prog_pkg;

  localparam logic [1:0] MODE_INJ  = 2'b00;
  localparam logic [1:0] MODE_TUN  = 2'b01;
  localparam logic [1:0] MODE_MEAS = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_LATCH,
    ST_SETTLE,
    ST_MEAS,
    ST_PULSE,
    ST_DONE
  } state_t;

  function automatic int sh_len(input int row_w, input int col_w);
    return 2 + row_w + col_w;
  endfunction

endpackage

// File: rtl/epot_scan_shifter.sv
// Two-phase MSB-first scan shifter for the island mux chain.
// Phase A presents data with clock low, phase B raises clock.
module epot_scan_shifter
  import epot_prog_pkg::*;
#(
  parameter int LEN = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load_i,
  input  logic           clr_i,
  input  logic [LEN-1:0] word_i,
  output logic           scan_clk_o,
  output logic           scan_data_o,
  output logic           scan_latch_o,
  output logic           last_o
);

  localparam int CW = $clog2(LEN + 1);

  logic [LEN-1:0] sreg_q;
  logic [CW-1:0]  cnt_q;
  logic           act_q;
  logic           ph_a_q;
  logic           sclk_q;
  logic           sdat_q;
  logic           lat_q;

  // High during the clock-high phase of the final bit.
  assign last_o = act_q & ~ph_a_q & (cnt_q == CW'(LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q <= '0;
      cnt_q  <= '0;
      act_q  <= 1'b0;
      ph_a_q <= 1'b0;
      sclk_q <= 1'b0;
      sdat_q <= 1'b0;
      lat_q  <= 1'b0;
    end else if (clr_i) begin
      sreg_q <= '0;
      cnt_q  <= '0;
      act_q  <= 1'b0;
      ph_a_q <= 1'b0;
      sclk_q <= 1'b0;
      sdat_q <= 1'b0;
      lat_q  <= 1'b0;
    end else if (load_i) begin
      sreg_q <= word_i;
      cnt_q  <= '0;
      act_q  <= 1'b1;
      ph_a_q <= 1'b1;
      sclk_q <= 1'b0;
      sdat_q <= word_i[LEN-1];
      lat_q  <= 1'b0;
    end else begin
      lat_q <= 1'b0;
      if (act_q) begin
        if (ph_a_q) begin
          sclk_q <= 1'b1;
          ph_a_q <= 1'b0;
        end else if (last_o) begin
          sclk_q <= 1'b0;
          sdat_q <= 1'b0;
          lat_q  <= 1'b1;
          act_q  <= 1'b0;
        end else begin
          sclk_q <= 1'b0;
          sdat_q <= sreg_q[LEN-2];
          sreg_q <= {sreg_q[LEN-2:0], 1'b0};
          cnt_q  <= cnt_q + CW'(1);
          ph_a_q <= 1'b1;
        end
      end
    end
  end

  assign scan_clk_o   = sclk_q;
  assign scan_data_o  = sdat_q;
  assign scan_latch_o = lat_q;

endmodule

// File: rtl/epot_prog_seq.sv
// EPOT program/measure sequencer: scans the cell address into the
// mux, then loops pulse/settle/measure against the comparator.
module epot_prog_seq
  import epot_prog_pkg::*;
#(
  parameter int ROW_W      = 4,
  parameter int COL_W      = 4,
  parameter int PW_W       = 16,
  parameter int CNT_W      = 8,
  parameter int SETTLE_CYC = 16,
  parameter int MEAS_CYC   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [ROW_W-1:0] cmd_row,
  input  logic [COL_W-1:0] cmd_col,
  input  logic [1:0]       cmd_mode,
  input  logic [PW_W-1:0]  cmd_pw,
  input  logic [CNT_W-1:0] cmd_max,
  input  logic             cmd_stop,
  input  logic             abort,
  input  logic             comp_in,
  output logic             scan_clk,
  output logic             scan_data,
  output logic             scan_latch,
  output logic             inj_en,
  output logic             tun_en,
  output logic             meas_en,
  output logic             busy,
  output logic             done_valid,
  output logic             done_ok,
  output logic [CNT_W-1:0] done_pulses
);

  localparam int SH_LEN = sh_len(ROW_W, COL_W);
  localparam int CYC_W  = PW_W;

  state_t           state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic             ok_q, ok_d;
  logic [1:0]       mode_q, mode_d;
  logic [PW_W-1:0]  pw_q, pw_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic             stop_q, stop_d;
  logic             inj_q, tun_q, meas_q;
  logic             load;
  logic             clr;
  logic             sh_last;
  logic             active;
  logic [PW_W-1:0]  pw_last;

  assign active  = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign clr     = abort & active;
  // A zero pulse width still yields a single-cycle pulse.
  assign pw_last = (pw_q == '0) ? '0 : pw_q - PW_W'(1);

  epot_scan_shifter #(
    .LEN(SH_LEN)
  ) u_shift (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load),
    .clr_i       (clr),
    .word_i      ({cmd_mode, cmd_row, cmd_col}),
    .scan_clk_o  (scan_clk),
    .scan_data_o (scan_data),
    .scan_latch_o(scan_latch),
    .last_o      (sh_last)
  );

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    pcnt_d  = pcnt_q;
    ok_d    = ok_q;
    mode_d  = mode_q;
    pw_d    = pw_q;
    max_d   = max_q;
    stop_d  = stop_q;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          mode_d = cmd_mode;
          pw_d   = cmd_pw;
          max_d  = cmd_max;
          stop_d = cmd_stop;
          pcnt_d = '0;
          ok_d   = 1'b0;
          cyc_d  = '0;
          if (cmd_mode == MODE_RSVD) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
            load    = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        if (sh_last) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        state_d = ST_SETTLE;
        cyc_d   = '0;
      end
      ST_SETTLE: begin
        if (cyc_q == CYC_W'(SETTLE_CYC - 1)) begin
          state_d = ST_MEAS;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      ST_MEAS: begin
        if (cyc_q == CYC_W'(MEAS_CYC - 1)) begin
          cyc_d = '0;
          if (mode_q == MODE_MEAS || comp_in == stop_q) begin
            state_d = ST_DONE;
            ok_d    = 1'b1;
          end else if (pcnt_q == max_q) begin
            state_d = ST_DONE;
            ok_d    = 1'b0;
          end else begin
            state_d = ST_PULSE;
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      ST_PULSE: begin
        if (cyc_q == pw_last) begin
          state_d = ST_SETTLE;
          cyc_d   = '0;
          pcnt_d  = pcnt_q + CNT_W'(1);
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Abort reports the pulses completed so far; a cut pulse is not counted.
    if (clr) begin
      state_d = ST_DONE;
      ok_d    = 1'b0;
      pcnt_d  = pcnt_q;
      cyc_d   = '0;
      load    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      pcnt_q  <= '0;
      ok_q    <= 1'b0;
      mode_q  <= MODE_INJ;
      pw_q    <= '0;
      max_q   <= '0;
      stop_q  <= 1'b0;
      inj_q   <= 1'b0;
      tun_q   <= 1'b0;
      meas_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      pcnt_q  <= pcnt_d;
      ok_q    <= ok_d;
      mode_q  <= mode_d;
      pw_q    <= pw_d;
      max_q   <= max_d;
      stop_q  <= stop_d;
      inj_q   <= (state_d == ST_PULSE) && (mode_d == MODE_INJ);
      tun_q   <= (state_d == ST_PULSE) && (mode_d == MODE_TUN);
      meas_q  <= (state_d == ST_SETTLE) || (state_d == ST_MEAS);
    end
  end

  assign inj_en      = inj_q;
  assign tun_en      = tun_q;
  assign meas_en     = meas_q;
  assign cmd_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign done_valid  = (state_q == ST_DONE);
  assign done_ok     = done_valid & ok_q;
  assign done_pulses = done_valid ? pcnt_q : '0;

endmodule

// File: tb/tb_epot_prog_seq.sv
// Directed self-checking bench for the EPOT programming sequencer.
module tb_epot_prog_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_row = '0;
  logic [3:0]  cmd_col = '0;
  logic [1:0]  cmd_mode = '0;
  logic [15:0] cmd_pw = '0;
  logic [7:0]  cmd_max = '0;
  logic        cmd_stop = 1'b0;
  logic        abort = 1'b0;
  logic        comp_in = 1'b0;
  logic        scan_clk, scan_data, scan_latch;
  logic        inj_en, tun_en, meas_en, busy;
  logic        done_valid, done_ok;
  logic [7:0]  done_pulses;

  int nchk = 0;
  int nfail = 0;

  epot_prog_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_row    (cmd_row),
    .cmd_col    (cmd_col),
    .cmd_mode   (cmd_mode),
    .cmd_pw     (cmd_pw),
    .cmd_max    (cmd_max),
    .cmd_stop   (cmd_stop),
    .abort      (abort),
    .comp_in    (comp_in),
    .scan_clk   (scan_clk),
    .scan_data  (scan_data),
    .scan_latch (scan_latch),
    .inj_en     (inj_en),
    .tun_en     (tun_en),
    .meas_en    (meas_en),
    .busy       (busy),
    .done_valid (done_valid),
    .done_ok    (done_ok),
    .done_pulses(done_pulses)
  );

  always #5 clk = ~clk;

  int inj_cyc = 0, inj_pul = 0, tun_cyc = 0, tun_pul = 0;
  int meas_cyc = 0, lat_cnt = 0, sbits = 0, done_cnt = 0, ovl = 0;
  logic [31:0] sword = '0;
  logic ip = 1'b0, tp = 1'b0, sp = 1'b0;

  always @(negedge clk) begin
    if (inj_en) inj_cyc++;
    if (inj_en && !ip) inj_pul++;
    if (tun_en) tun_cyc++;
    if (tun_en && !tp) tun_pul++;
    if (meas_en) meas_cyc++;
    if (scan_clk && !sp) begin
      sword = {sword[30:0], scan_data};
      sbits++;
    end
    if (scan_latch) lat_cnt++;
    if (done_valid) done_cnt++;
    if (int'(inj_en) + int'(tun_en) + int'(meas_en) > 1) ovl++;
    ip = inj_en;
    tp = tun_en;
    sp = scan_clk;
  end

  int b_inj_cyc, b_inj_pul, b_tun_cyc, b_tun_pul;
  int b_meas, b_lat, b_sbits, b_done;

  task automatic snap();
    b_inj_cyc = inj_cyc;
    b_inj_pul = inj_pul;
    b_tun_cyc = tun_cyc;
    b_tun_pul = tun_pul;
    b_meas    = meas_cyc;
    b_lat     = lat_cnt;
    b_sbits   = sbits;
    b_done    = done_cnt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] r, input logic [3:0] c,
                      input logic [1:0] m, input logic [15:0] pw,
                      input logic [7:0] mx, input logic st);
    int n;
    cmd_row   = r;
    cmd_col   = c;
    cmd_mode  = m;
    cmd_pw    = pw;
    cmd_max   = mx;
    cmd_stop  = st;
    cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    nchk++;
    if (n >= 2000) begin
      nfail++;
      $display("FAIL send_ready_timeout: waited %0d cycles", n);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound, input int comp_after,
                           output int lat);
    int n;
    n = 0;
    while (done_valid !== 1'b1 && n < bound) begin
      if (comp_after >= 0)
        comp_in = ((inj_pul + tun_pul - b_inj_pul - b_tun_pul) >= comp_after);
      tick();
      n++;
    end
    lat = n;
    nchk++;
    if (done_valid !== 1'b1) begin
      nfail++;
      $display("FAIL done_timeout: no done_valid after %0d cycles", n);
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    nchk++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL reset_ready: ready=%b busy=%b want 1/0", cmd_ready, busy);
    end
    nchk++;
    if ({scan_clk, scan_data, scan_latch, inj_en, tun_en, meas_en} !== 6'b0) begin
      nfail++;
      $display("FAIL reset_outs: got %b want 000000",
               {scan_clk, scan_data, scan_latch, inj_en, tun_en, meas_en});
    end
    nchk++;
    if (done_valid !== 1'b0 || done_ok !== 1'b0 || done_pulses !== 8'd0) begin
      nfail++;
      $display("FAIL reset_done: v=%b ok=%b p=%0d want 0", done_valid, done_ok,
               done_pulses);
    end
    abort = 1'b1;
    tick();
    tick();
    abort = 1'b0;
    nchk++;
    if (busy !== 1'b0 || done_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      nfail++;
      $display("FAIL idle_abort: busy=%b done=%b ready=%b want 0/0/1", busy,
               done_valid, cmd_ready);
    end
  endtask

  task automatic test_meas_only();
    int lat;
    logic [9:0] w;
    comp_in = 1'b1;
    snap();
    send(4'd3, 4'd5, 2'b10, 16'd0, 8'd0, 1'b0);
    wait_done(200, -1, lat);
    w = sword[9:0];
    nchk++;
    if (lat != 41) begin
      nfail++;
      $display("FAIL meas_latency: got %0d want 41", lat);
    end
    nchk++;
    if (done_ok !== 1'b1 || done_pulses !== 8'd0) begin
      nfail++;
      $display("FAIL meas_result: ok=%b p=%0d want 1/0", done_ok, done_pulses);
    end
    nchk++;
    if (sbits - b_sbits != 10 || w !== 10'b10_0011_0101) begin
      nfail++;
      $display("FAIL meas_scan: bits=%0d word=%b want 10 / 1000110101",
               sbits - b_sbits, w);
    end
    nchk++;
    if (lat_cnt - b_lat != 1) begin
      nfail++;
      $display("FAIL meas_latch: got %0d want 1", lat_cnt - b_lat);
    end
    nchk++;
    if (meas_cyc - b_meas != 20) begin
      nfail++;
      $display("FAIL meas_en_cycles: got %0d want 20", meas_cyc - b_meas);
    end
    nchk++;
    if (inj_cyc - b_inj_cyc + tun_cyc - b_tun_cyc != 0) begin
      nfail++;
      $display("FAIL meas_no_pulse: got %0d want 0",
               inj_cyc - b_inj_cyc + tun_cyc - b_tun_cyc);
    end
    tick();
    nchk++;
    if (done_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      nfail++;
      $display("FAIL meas_oneshot: done=%b ready=%b want 0/1", done_valid,
               cmd_ready);
    end
  endtask

  task automatic test_inject();
    int lat;
    comp_in = 1'b0;
    snap();
    send(4'd1, 4'd2, 2'b00, 16'd8, 8'd10, 1'b1);
    wait_done(1000, 3, lat);
    nchk++;
    if (lat != 125) begin
      nfail++;
      $display("FAIL inj_latency: got %0d want 125", lat);
    end
    nchk++;
    if (done_ok !== 1'b1 || done_pulses !== 8'd3) begin
      nfail++;
      $display("FAIL inj_result: ok=%b p=%0d want 1/3", done_ok, done_pulses);
    end
    nchk++;
    if (inj_pul - b_inj_pul != 3 || inj_cyc - b_inj_cyc != 24) begin
      nfail++;
      $display("FAIL inj_pulses: n=%0d cyc=%0d want 3/24", inj_pul - b_inj_pul,
               inj_cyc - b_inj_cyc);
    end
    nchk++;
    if (meas_cyc - b_meas != 80 || tun_cyc - b_tun_cyc != 0) begin
      nfail++;
      $display("FAIL inj_meas: meas=%0d tun=%0d want 80/0", meas_cyc - b_meas,
               tun_cyc - b_tun_cyc);
    end
    tick();
  endtask

  task automatic test_tunnel();
    int lat;
    comp_in = 1'b0;
    snap();
    send(4'd15, 4'd0, 2'b01, 16'd0, 8'd2, 1'b1);
    wait_done(1000, -1, lat);
    nchk++;
    if (lat != 83) begin
      nfail++;
      $display("FAIL tun_latency: got %0d want 83", lat);
    end
    nchk++;
    if (done_ok !== 1'b0 || done_pulses !== 8'd2) begin
      nfail++;
      $display("FAIL tun_result: ok=%b p=%0d want 0/2", done_ok, done_pulses);
    end
    nchk++;
    if (tun_pul - b_tun_pul != 2 || tun_cyc - b_tun_cyc != 2 ||
        inj_cyc - b_inj_cyc != 0) begin
      nfail++;
      $display("FAIL tun_pulses: n=%0d cyc=%0d inj=%0d want 2/2/0",
               tun_pul - b_tun_pul, tun_cyc - b_tun_cyc, inj_cyc - b_inj_cyc);
    end
    tick();
  endtask

  task automatic test_max_zero();
    int lat;
    comp_in = 1'b0;
    snap();
    send(4'd0, 4'd0, 2'b00, 16'd5, 8'd0, 1'b1);
    wait_done(200, -1, lat);
    nchk++;
    if (lat != 41 || done_ok !== 1'b0 || done_pulses !== 8'd0) begin
      nfail++;
      $display("FAIL max0_miss: lat=%0d ok=%b p=%0d want 41/0/0", lat, done_ok,
               done_pulses);
    end
    nchk++;
    if (inj_cyc - b_inj_cyc != 0) begin
      nfail++;
      $display("FAIL max0_no_pulse: got %0d want 0", inj_cyc - b_inj_cyc);
    end
    tick();
    send(4'd0, 4'd0, 2'b00, 16'd5, 8'd0, 1'b0);
    wait_done(200, -1, lat);
    nchk++;
    if (done_ok !== 1'b1 || done_pulses !== 8'd0) begin
      nfail++;
      $display("FAIL max0_hit: ok=%b p=%0d want 1/0", done_ok, done_pulses);
    end
    tick();
  endtask

  task automatic test_abort();
    int n, lat;
    comp_in = 1'b0;
    send(4'd2, 4'd2, 2'b00, 16'd100, 8'd10, 1'b1);
    n = 0;
    while (inj_en !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    nchk++;
    if (inj_en !== 1'b1) begin
      nfail++;
      $display("FAIL abort_no_pulse: inj_en=%b want 1", inj_en);
    end
    repeat (39) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    nchk++;
    if (inj_en !== 1'b0 || {scan_clk, scan_data, scan_latch, tun_en, meas_en} !== 5'b0) begin
      nfail++;
      $display("FAIL abort_outs: inj=%b others=%b want 0", inj_en,
               {scan_clk, scan_data, scan_latch, tun_en, meas_en});
    end
    nchk++;
    if (done_valid !== 1'b1 || done_ok !== 1'b0 || done_pulses !== 8'd0) begin
      nfail++;
      $display("FAIL abort_done: v=%b ok=%b p=%0d want 1/0/0", done_valid,
               done_ok, done_pulses);
    end
    tick();
    nchk++;
    if (cmd_ready !== 1'b1 || done_valid !== 1'b0) begin
      nfail++;
      $display("FAIL abort_idle: ready=%b done=%b want 1/0", cmd_ready,
               done_valid);
    end
    comp_in = 1'b1;
    send(4'd3, 4'd5, 2'b10, 16'd0, 8'd0, 1'b0);
    repeat (4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    nchk++;
    if (scan_clk !== 1'b0 || scan_data !== 1'b0 || done_valid !== 1'b1 ||
        done_ok !== 1'b0) begin
      nfail++;
      $display("FAIL abort_shift: sclk=%b sdat=%b v=%b ok=%b want 0/0/1/0",
               scan_clk, scan_data, done_valid, done_ok);
    end
    tick();
    send(4'd3, 4'd5, 2'b10, 16'd0, 8'd0, 1'b0);
    wait_done(200, -1, lat);
    nchk++;
    if (done_ok !== 1'b1 || lat != 41) begin
      nfail++;
      $display("FAIL abort_recover: ok=%b lat=%0d want 1/41", done_ok, lat);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    snap();
    send(4'd3, 4'd5, 2'b11, 16'd0, 8'd4, 1'b0);
    nchk++;
    if (done_valid !== 1'b1 || done_ok !== 1'b0 || done_pulses !== 8'd0) begin
      nfail++;
      $display("FAIL rsvd_done: v=%b ok=%b p=%0d want 1/0/0", done_valid,
               done_ok, done_pulses);
    end
    tick();
    nchk++;
    if (sbits != b_sbits || lat_cnt != b_lat || cmd_ready !== 1'b1) begin
      nfail++;
      $display("FAIL rsvd_scan: bits=%0d latch=%0d ready=%b want 0/0/1",
               sbits - b_sbits, lat_cnt - b_lat, cmd_ready);
    end
    comp_in = 1'b1;
    send(4'd3, 4'd5, 2'b10, 16'd0, 8'd0, 1'b0);
    cmd_mode  = 2'b11;
    cmd_valid = 1'b1;
    nchk++;
    if (cmd_ready !== 1'b0) begin
      nfail++;
      $display("FAIL busy_ready: got %b want 0", cmd_ready);
    end
    wait_done(200, -1, lat);
    nchk++;
    if (done_ok !== 1'b1 || lat != 41) begin
      nfail++;
      $display("FAIL busy_first: ok=%b lat=%0d want 1/41", done_ok, lat);
    end
    tick();
    nchk++;
    if (cmd_ready !== 1'b1) begin
      nfail++;
      $display("FAIL busy_ready_back: got %b want 1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    nchk++;
    if (done_valid !== 1'b1 || done_ok !== 1'b0) begin
      nfail++;
      $display("FAIL busy_second: v=%b ok=%b want 1/0", done_valid, done_ok);
    end
    tick();
  endtask

  task automatic test_async_reset();
    int n;
    comp_in = 1'b0;
    snap();
    send(4'd1, 4'd1, 2'b00, 16'd50, 8'd5, 1'b1);
    n = 0;
    while (meas_en !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    nchk++;
    if ({scan_clk, scan_data, scan_latch, inj_en, tun_en, meas_en, busy,
         done_valid} !== 8'b0) begin
      nfail++;
      $display("FAIL rst_settle: outs=%b want 0", {scan_clk, scan_data,
               scan_latch, inj_en, tun_en, meas_en, busy, done_valid});
    end
    tick();
    rst_n = 1'b1;
    tick();
    nchk++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL rst_settle_ready: ready=%b busy=%b want 1/0", cmd_ready,
               busy);
    end
    send(4'd1, 4'd1, 2'b00, 16'd50, 8'd5, 1'b1);
    n = 0;
    while (inj_en !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    repeat (10) tick();
    #2;
    rst_n = 1'b0;
    #1;
    nchk++;
    if ({inj_en, tun_en, meas_en, busy, done_valid} !== 5'b0) begin
      nfail++;
      $display("FAIL rst_pulse: outs=%b want 0",
               {inj_en, tun_en, meas_en, busy, done_valid});
    end
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    nchk++;
    if (cmd_ready !== 1'b1 || done_cnt != b_done) begin
      nfail++;
      $display("FAIL rst_no_done: ready=%b dones=%0d want 1/0", cmd_ready,
               done_cnt - b_done);
    end
    nchk++;
    if (ovl != 0) begin
      nfail++;
      $display("FAIL enable_overlap: got %0d want 0", ovl);
    end
  endtask

  initial begin
    test_reset();
    test_meas_only();
    test_inject();
    test_tunnel();
    test_max_zero();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk,
             nfail);
    $finish;
  end

endmodule
